serial_add_seq: RTL and testbench

- Bit-serial multi-bit adder sequencer built around the team's gate-level half-adder cell.
- Time-multiplexes one full-adder stage, made of two half-adder instances plus an OR on the carries, across WIDTH bit positions, LSB first.
- Provides a start/busy/done handshake so test modules and higher-level datapaths can request additions without a parallel ripple adder.

---
 rtl/serial_add_seq.sv | 189 ++++++++++++++++++
 tb/tb_serial_add_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial unsigned adder sequencer.
//
// One full-adder stage (two half-adder cells plus an OR on the carries) is
// reused across WIDTH bit positions, LSB first, one bit per clock. A
// start/busy/done handshake frames each operation.
//
// Parameters:
//   WIDTH  operand/result width, 1..32
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request pulse, only sampled in IDLE
//   a, b   operands, captured on the accepting edge
//   cin    carry-in, captured on the accepting edge
//          (present only with SERIAL_ADD_CIN_EN defined)
//   busy   high while bits are being processed
//   done   one-cycle completion pulse
//   sum    result, held until the next operation completes
//   cout   final carry-out, held alongside sum
//
// Build option: define SERIAL_ADD_CIN_EN to add the cin port. Without it,
// the initial carry is always 0.

module half_add_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  xor g_s (s, a, b);
  and g_c (c, a, b);
endmodule

// state | meaning
// ------+------------------------------------------------
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | processing one bit per edge, LSB first
// DONE  | done pulse cycle; returns to IDLE unconditionally
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_CIN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cin_init;
  logic             s0, c0, s1, c1;
  logic             carry_new;
  logic [WIDTH-1:0] res_shifted;

`ifdef SERIAL_ADD_CIN_EN
  assign cin_init = cin;
`else
  assign cin_init = 1'b0;
`endif

  half_add_cell u_ha0 (
    .a (a_sr_q[0]),
    .b (b_sr_q[0]),
    .s (s0),
    .c (c0)
  );

  half_add_cell u_ha1 (
    .a (s0),
    .b (carry_q),
    .s (s1),
    .c (c1)
  );

  assign carry_new = c0 | c1;

  // New sum bit enters at the MSB; after WIDTH shifts the LSB-first bits
  // have settled into their natural positions. Written this way so that
  // WIDTH=1 needs no special-case slice.
  always_comb begin
    res_shifted            = res_sr_q >> 1;
    res_shifted[WIDTH-1]   = s1;
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          res_sr_d = '0;
          carry_d  = cin_init;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = res_shifted;
        carry_d  = carry_new;
        cnt_d    = cnt_q + CW'(1);
        // Last bit: publish the complete result in the same edge so that
        // sum never shows a partial value.
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = res_shifted;
          cout_d  = carry_new;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed self-checking bench for serial_add_seq
// (WIDTH=8). Expected values are hand-computed constants.

module tb_serial_add_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef SERIAL_ADD_CIN_EN
  logic         cin;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_cmp;
  int n_mis;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADD_CIN_EN
    .cin   (cin),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and follow it to its done pulse. If pulse_at >= 0,
  // a second start with a=b=FF is raised during that RUN sample, which
  // must be ignored.
  task automatic op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                    input int pulse_at, input logic [W-1:0] exp_sum, input logic exp_cout);
    int lat;
    int busy_n;
    int chg;
    logic [W-1:0] prev;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    prev = sum;
    lat = 0;
    busy_n = 0;
    chg = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      if (sum !== prev) chg++;
      if (lat == pulse_at) begin
        a = '1;
        b = '1;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      lat++;
    end
    chk({tag, " latency"}, lat, W);
    chk({tag, " busy_cycles"}, busy_n, W);
    chk({tag, " busy_at_done"}, busy, 0);
    chk({tag, " sum_stable"}, chg, 0);
    chk({tag, " sum"}, sum, exp_sum);
    chk({tag, " cout"}, cout, exp_cout);
    tick();
    chk({tag, " done_width"}, done, 0);
  endtask

  initial begin
    int extra_done;
    int busy_seen;
    int ndone;
    int t_done[3];
    int cyc;

    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef SERIAL_ADD_CIN_EN
    cin = 1'b0;
`endif
    #3;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    op("5a+25", 8'h5A, 8'h25, -1, 8'h7F, 1'b0);
    op("ff+01", 8'hFF, 8'h01, -1, 8'h00, 1'b1);
    repeat (5) tick();
    chk("hold sum", sum, 8'h00);
    chk("hold cout", cout, 1);

    op("10+20 ignore", 8'h10, 8'h20, 2, 8'h30, 1'b0);
    busy_seen = 0;
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) busy_seen++;
      if (done) extra_done++;
      tick();
    end
    chk("ignored start busy", busy_seen, 0);
    chk("ignored start done", extra_done, 0);

    // Reset mid-RUN, mid-cycle.
    @(negedge clk);
    a = 8'hAA;
    b = 8'h55;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("pre-abort busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort sum", sum, 0);
    chk("abort cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    extra_done = 0;
    busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) extra_done++;
      if (busy) busy_seen++;
    end
    chk("post-abort done", extra_done, 0);
    chk("post-abort busy", busy_seen, 0);
    op("01+02", 8'h01, 8'h02, -1, 8'h03, 1'b0);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 8'h80;
    b = 8'h80;
    start = 1'b1;
    ndone = 0;
    cyc = 0;
    while (ndone < 3 && cyc < 60) begin
      tick();
      cyc++;
      if (done) begin
        t_done[ndone] = cyc;
        chk("b2b sum", sum, 8'h00);
        chk("b2b cout", cout, 1);
        ndone++;
      end
    end
    start = 1'b0;
    chk("b2b count", ndone, 3);
    if (ndone == 3) begin
      chk("b2b period1", t_done[1] - t_done[0], W + 2);
      chk("b2b period2", t_done[2] - t_done[1], W + 2);
    end
    repeat (12) tick();

`ifdef SERIAL_ADD_CIN_EN
    cin = 1'b1;
    op("ff+00+1", 8'hFF, 8'h00, -1, 8'h00, 1'b1);
    op("01+01+1", 8'h01, 8'h01, -1, 8'h03, 1'b0);
    cin = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
